fetch_queue: RTL and testbench



---
 rtl/fetch_queue.sv | 119 +++++++++++
 tb/tb_fetch_queue.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry {pc, inst} FIFO between the i-cache and the IF/ID register.
// Define FETCH_QUEUE_STATS_EN to add full_cycles / max_count statistics outputs.
module fetch_queue #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0] in_inst,
    output logic                  in_ready,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_inst,
`ifdef FETCH_QUEUE_STATS_EN
    output logic [31:0]           full_cycles,
    output logic [CNT_W-1:0]      max_count,
`endif
    output logic [CNT_W-1:0]      count
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_WIDTH-1:0] pc_mem_r   [DEPTH];
    logic [DATA_WIDTH-1:0] inst_mem_r [DEPTH];
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  push_s;
    logic                  pop_s;

    // Handshake decode and head read; in_ready depends only on the registered count.
    always_comb begin
        in_ready  = (count_r < FULL_CNT);
        out_valid = (count_r != CNT_W'(0));
        push_s    = in_valid & in_ready & ~flush;
        pop_s     = out_valid & ~stall & ~flush;
        if (out_valid) begin
            out_pc   = pc_mem_r[rd_ptr_r];
            out_inst = inst_mem_r[rd_ptr_r];
        end else begin
            out_pc   = {ADDR_WIDTH{1'b0}};
            out_inst = {DATA_WIDTH{1'b0}};
        end
    end

    assign count = count_r;

    // Pointer and occupancy state; reset outranks flush, flush outranks stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_r <= PTR_W'(0);
            wr_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else if (flush) begin
            rd_ptr_r <= PTR_W'(0);
            wr_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are never cleared because out_* is masked while empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_r[wr_ptr_r]   <= in_pc;
            inst_mem_r[wr_ptr_r] <= in_inst;
        end
    end

`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0]      full_cycles_r;
    logic [CNT_W-1:0] max_count_r;

    // Back-pressure cycle counter (saturating) and occupancy high-water mark; flush leaves them alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_cycles_r <= 32'd0;
            max_count_r   <= CNT_W'(0);
        end else begin
            if ((count_r == FULL_CNT) && in_valid && (full_cycles_r != 32'hFFFF_FFFF)) begin
                full_cycles_r <= full_cycles_r + 32'd1;
            end else begin
                full_cycles_r <= full_cycles_r;
            end
            if (count_r > max_count_r) begin
                max_count_r <= count_r;
            end else begin
                max_count_r <= max_count_r;
            end
        end
    end

    assign full_cycles = full_cycles_r;
    assign max_count   = max_count_r;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [AW-1:0]    in_pc;
    logic [DW-1:0]    in_inst;
    logic             in_ready;
    logic             stall;
    logic             flush;
    logic             out_valid;
    logic [AW-1:0]    out_pc;
    logic [DW-1:0]    out_inst;
    logic [CNT_W-1:0] count;
`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0]      full_cycles;
    logic [CNT_W-1:0] max_count;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] inst;
    } entry_t;

    entry_t model_q[$];

    fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
        .stall(stall), .flush(flush),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
`ifdef FETCH_QUEUE_STATS_EN
        .full_cycles(full_cycles), .max_count(max_count),
`endif
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [AW-1:0] pc, input logic [DW-1:0] inst,
                         input logic st, input logic fl, input logic rs);
        in_valid = v;
        in_pc    = pc;
        in_inst  = inst;
        stall    = st;
        flush    = fl;
        rst_n    = rs;
        #1;
    endtask

    // Reference: FIFO of entries; queue cleared by reset or flush, else pop-then-push.
    task automatic advance();
        int     sz;
        entry_t e;
        sz = model_q.size();
        if (!rst_n || flush) begin
            model_q.delete();
        end else begin
            if (sz > 0 && !stall) void'(model_q.pop_front());
            if (in_valid && sz < DEPTH) begin
                e.pc   = in_pc;
                e.inst = in_inst;
                model_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_queue();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        advance();
    endtask

    task automatic test_reset();
        drive(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        advance();
        advance();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc got %h want 0", out_pc); end
        if (out_inst !== 32'h0) begin errors++; $display("FAIL reset_out_inst got %h want 0", out_inst); end
    endtask

    task automatic test_single_push();
        clear_queue();
        drive(1'b1, 32'h0040_0000, 32'h2008_0005, 1'b0, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL no_bypass got out_valid=%0b want 0", out_valid); end
        advance();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        checks += 4;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", out_valid); end
        if (out_pc !== 32'h0040_0000) begin errors++; $display("FAIL single_pc got %h want 00400000", out_pc); end
        if (out_inst !== 32'h2008_0005) begin errors++; $display("FAIL single_inst got %h want 20080005", out_inst); end
        if (count !== 3'd1) begin errors++; $display("FAIL single_count got %0d want 1", count); end
        advance();
        checks += 3;
        if (count !== 3'd0) begin errors++; $display("FAIL single_drain_count got %0d want 0", count); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain_valid got %0b want 0", out_valid); end
        if (out_pc !== 32'h0) begin errors++; $display("FAIL single_drain_pc got %h want 0", out_pc); end
    endtask

    task automatic test_fill_stall();
        logic [DW-1:0] insts [5];
        clear_queue();
        for (int i = 0; i < 5; i++) begin
            insts[i] = $urandom;
            drive(1'b1, 32'h100 + 32'(4 * i), insts[i], 1'b1, 1'b0, 1'b1);
            checks++;
            if (in_ready !== (i < 4)) begin errors++; $display("FAIL fill_in_ready[%0d] got %0b want %0b", i, in_ready, (i < 4)); end
            advance();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        checks += 2;
        if (count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d want 4", count); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got %0b want 0", in_ready); end
        for (int i = 0; i < 4; i++) begin
            checks += 2;
            if (out_pc !== 32'h100 + 32'(4 * i)) begin errors++; $display("FAIL fill_drain_pc[%0d] got %h want %h", i, out_pc, 32'h100 + 32'(4 * i)); end
            if (out_inst !== insts[i]) begin errors++; $display("FAIL fill_drain_inst[%0d] got %h want %h", i, out_inst, insts[i]); end
            advance();
        end
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL fill_end_count got %0d want 0 (0x110 must be dropped)", count); end
    endtask

    task automatic test_wrap();
        clear_queue();
        for (int k = 0; k <= 10; k++) begin
            if (k < 10) drive(1'b1, 32'(4 * k), 32'hA000_0000 + 32'(k), 1'b0, 1'b0, 1'b1);
            else        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
            if (k >= 1) begin
                checks += 3;
                if (count !== 3'd1) begin errors++; $display("FAIL wrap_count[%0d] got %0d want 1", k, count); end
                if (out_pc !== 32'(4 * (k - 1))) begin errors++; $display("FAIL wrap_pc[%0d] got %h want %h", k, out_pc, 32'(4 * (k - 1))); end
                if (out_inst !== 32'hA000_0000 + 32'(k - 1)) begin errors++; $display("FAIL wrap_inst[%0d] got %h", k, out_inst); end
            end
            advance();
        end
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL wrap_end_count got %0d want 0", count); end
    endtask

    task automatic test_flush();
        clear_queue();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h180 + 32'(4 * i), $urandom, 1'b1, 1'b0, 1'b1);
            advance();
        end
        drive(1'b1, 32'h200, 32'h0000_0200, 1'b1, 1'b1, 1'b1);
        checks++;
        if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count got %0d want 3", count); end
        advance();
        drive(1'b1, 32'h300, 32'h0000_0300, 1'b0, 1'b0, 1'b1);
        checks += 2;
        if (count !== 3'd0) begin errors++; $display("FAIL flush_count got %0d want 0", count); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", out_valid); end
        advance();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        checks += 2;
        if (out_pc !== 32'h300) begin errors++; $display("FAIL flush_next_pc got %h want 300", out_pc); end
        if (count !== 3'd1) begin errors++; $display("FAIL flush_next_count got %0d want 1", count); end
        advance();
    endtask

    task automatic test_random();
        logic [AW-1:0] exp_pc;
        logic [DW-1:0] exp_inst;
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(2, 0) != 0), $urandom, $urandom,
                  ($urandom_range(2, 0) == 0), ($urandom_range(15, 0) == 0),
                  ($urandom_range(63, 0) != 0));
            exp_pc   = (model_q.size() != 0) ? model_q[0].pc   : 32'h0;
            exp_inst = (model_q.size() != 0) ? model_q[0].inst : 32'h0;
            checks += 5;
            if (count !== CNT_W'(model_q.size())) begin errors++; $display("FAIL rand_count[%0d] got %0d want %0d", n, count, model_q.size()); end
            if (out_valid !== (model_q.size() != 0)) begin errors++; $display("FAIL rand_valid[%0d] got %0b", n, out_valid); end
            if (in_ready !== (model_q.size() < DEPTH)) begin errors++; $display("FAIL rand_ready[%0d] got %0b", n, in_ready); end
            if (out_pc !== exp_pc) begin errors++; $display("FAIL rand_pc[%0d] got %h want %h", n, out_pc, exp_pc); end
            if (out_inst !== exp_inst) begin errors++; $display("FAIL rand_inst[%0d] got %h want %h", n, out_inst, exp_inst); end
            advance();
        end
    endtask

`ifdef FETCH_QUEUE_STATS_EN
    task automatic test_stats();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        advance();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h500 + 32'(4 * i), $urandom, 1'b1, 1'b0, 1'b1);
            advance();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h600, 32'h0, 1'b1, 1'b0, 1'b1);
            advance();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        checks += 2;
        if (full_cycles !== 32'd5) begin errors++; $display("FAIL stats_full_cycles got %0d want 5", full_cycles); end
        if (max_count !== 3'd4) begin errors++; $display("FAIL stats_max_count got %0d want 4", max_count); end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
        advance();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        checks += 2;
        if (full_cycles !== 32'd5) begin errors++; $display("FAIL stats_flush_full_cycles got %0d want 5", full_cycles); end
        if (max_count !== 3'd4) begin errors++; $display("FAIL stats_flush_max_count got %0d want 4", max_count); end
    endtask
`endif

    initial begin
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_single_push();
        test_fill_stall();
        test_wrap();
        test_flush();
        test_random();
`ifdef FETCH_QUEUE_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
